// File: rtl/sram_pkg.sv
// Shared types and constants for the cache-side SRAM controller.
// Two 16-bit halfword phases make up each 32-bit word access.
package sram_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic HW_LO = 1'b0;
  localparam logic HW_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: reloads to W on phase entry and flags the
// final cycle of the phase (WE_N release, data capture, phase advance).
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(W);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/sram_controller.sv
// 32-bit word requests split into two 16-bit async SRAM accesses.
// Optional `SRAM_BASE_OFFSET_EN subtracts BASE_ADDR before mapping.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        sram_address,
  input  logic [31:0]        sram_wdata,
  input  logic               sram_read,
  input  logic               sram_write,
  output logic [31:0]        sram_rdata,
  output logic               sram_ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  state_t state;
  state_t state_nx;

  logic        is_wr;
  logic        last;
  logic        load;
  logic        drive;
  logic        hw_sel;
  logic        req;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] a;
  logic        unused_bits;

`ifdef SRAM_BASE_OFFSET_EN
  assign a = sram_address - BASE_ADDR;
  assign unused_bits = ^{a[31:19], a[1:0]};
`else
  assign a = sram_address;
  assign unused_bits = ^{a[31:19], a[1:0], BASE_ADDR};
`endif

  assign req = sram_write | sram_read;

  sram_wait_counter #(
    .W(WAIT_CYCLES)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .load(load),
    .last(last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr      <= 1'b0;
      sram_rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q <= a[18:2];
        is_wr  <= sram_write;
        if (sram_write) begin
          wdata_q <= sram_wdata;
        end
      end
      if (!is_wr && last) begin
        if (state == LOW) begin
          sram_rdata[15:0] <= SRAM_DQ;
        end
        if (state == HIGH) begin
          sram_rdata[31:16] <= SRAM_DQ;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    drive      = 1'b0;
    hw_sel     = HW_LO;
    sram_ready = 1'b0;
    SRAM_WE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_CE_N  = 1'b1;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = LOW;
          load     = 1'b1;
        end
      end
      LOW, HIGH: begin
        SRAM_CE_N = 1'b0;
        hw_sel    = (state == HIGH) ? HW_HI : HW_LO;
        if (is_wr) begin
          drive     = 1'b1;
          SRAM_WE_N = last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
        if (last) begin
          state_nx = (state == LOW) ? HIGH : DONE;
          load     = (state == LOW);
        end
      end
      DONE: begin
        sram_ready = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign SRAM_ADDR = {addr_q, hw_sel};
  assign SRAM_UB_N = SRAM_CE_N;
  assign SRAM_LB_N = SRAM_CE_N;

  // Only the controller drives the bus, and only while writing.
  assign SRAM_DQ = drive ? (hw_sel ? wdata_q[31:16] : wdata_q[15:0])
                         : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM.
// Works with or without `SRAM_BASE_OFFSET_EN.
module tb_sram_controller;

  localparam int W = 2;
`ifdef SRAM_BASE_OFFSET_EN
  localparam logic [31:0] OFF = 32'd1024;
`else
  localparam logic [31:0] OFF = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_rdata;
  logic        sram_ready;
  logic [17:0] addr;
  wire  [15:0] dq;
  logic        we_n;
  logic        oe_n;
  logic        ce_n;
  logic        ub_n;
  logic        lb_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:262143];

  sram_controller #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (32'd1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sram_address(sram_address),
    .sram_wdata  (sram_wdata),
    .sram_read   (sram_read),
    .sram_write  (sram_write),
    .sram_rdata  (sram_rdata),
    .sram_ready  (sram_ready),
    .SRAM_ADDR   (addr),
    .SRAM_DQ     (dq),
    .SRAM_WE_N   (we_n),
    .SRAM_OE_N   (oe_n),
    .SRAM_CE_N   (ce_n),
    .SRAM_UB_N   (ub_n),
    .SRAM_LB_N   (lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dq = (!oe_n && !ce_n && we_n) ? mem[addr] : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce_n && !we_n) mem[addr] <= dq;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] hw_addr(input logic [31:0] b,
                                          input logic hi);
    logic [31:0] a;
    a = b - OFF;
    return {a[18:2], hi};
  endfunction

  task automatic access(input logic wr, input logic rd,
                        input logic [31:0] ba, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input string tag);
    logic hi;
    int   pc;
    sram_write   = wr;
    sram_read    = rd;
    sram_address = ba;
    sram_wdata   = wd;
    chk({tag, "_idle_ce"}, 32'(ce_n), 32'd1);
    for (int k = 1; k <= 2 * W; k++) begin
      step();
      if (k == 1) begin
        sram_write   = 1'b0;
        sram_read    = 1'b0;
        sram_address = 32'hFFFF_FFFC;
        sram_wdata   = 32'h0;
      end
      hi = (k > W);
      pc = hi ? k - W : k;
      chk({tag, "_rdy0"}, 32'(sram_ready), 32'd0);
      chk({tag, "_ce"}, 32'({ce_n, ub_n, lb_n}), 32'd0);
      chk({tag, "_addr"}, 32'(addr), 32'(hw_addr(ba, hi)));
      if (wr) begin
        chk({tag, "_we"}, 32'(we_n), (pc == W) ? 32'd1 : 32'd0);
        chk({tag, "_oe"}, 32'(oe_n), 32'd1);
        chk({tag, "_dq"}, {16'h0, dq}, {16'h0, hi ? wd[31:16] : wd[15:0]});
      end else begin
        chk({tag, "_we"}, 32'(we_n), 32'd1);
        chk({tag, "_oe"}, 32'(oe_n), 32'd0);
      end
    end
    step();
    chk({tag, "_rdy1"}, 32'(sram_ready), 32'd1);
    chk({tag, "_ce_done"}, 32'(ce_n), 32'd1);
    if (!wr) chk({tag, "_rdata"}, sram_rdata, exp_rd);
    step();
    chk({tag, "_rdy_off"}, 32'(sram_ready), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, 32'({we_n, oe_n, ce_n, ub_n, lb_n}), 32'h1F);
    chk({tag, "_rdy"}, 32'(sram_ready), 32'd0);
    chk({tag, "_rdata"}, sram_rdata, 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_dq"}, {16'h0, dq}, {16'h0, 16'hzzzz});
  endtask

  initial begin
    int r1;
    int r2;
    int extra;
    rst          = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;

    #12 rst = 1'b1;
    #1 chk_reset("rst");
    step();
    step();
    rst = 1'b0;
    step();

    mem[hw_addr(32'h404, 1'b0)] = 16'hF00D;
    mem[hw_addr(32'h404, 1'b1)] = 16'hCAFE;

    access(1'b1, 1'b0, 32'h400, 32'hDEADBEEF, 32'h0, "wr0");
    chk("mem_lo", 32'(mem[hw_addr(32'h400, 1'b0)]), 32'hBEEF);
    chk("mem_hi", 32'(mem[hw_addr(32'h400, 1'b1)]), 32'hDEAD);

    access(1'b0, 1'b1, 32'h400, 32'h0, 32'hDEADBEEF, "rd0");
    step();
    step();
    chk("rd0_hold", sram_rdata, 32'hDEADBEEF);

    r1 = -1;
    r2 = -1;
    sram_read    = 1'b1;
    sram_address = 32'h404;
    for (int c = 1; c <= 30 && r2 < 0; c++) begin
      step();
      if (sram_ready) begin
        if (r1 < 0) begin
          r1 = c;
          chk("fill_w0", sram_rdata, 32'hCAFEF00D);
          sram_address = 32'h400;
        end else begin
          r2 = c;
          chk("fill_w1", sram_rdata, 32'hDEADBEEF);
          sram_read = 1'b0;
        end
      end
    end
    sram_read = 1'b0;
    chk("fill_lat", r1, 32'd5);
    chk("fill_gap", r2 - r1, 32'd6);
    step();

    access(1'b1, 1'b1, 32'h408, 32'h12345678, 32'h0, "both");
    chk("wr_keeps_rdata", sram_rdata, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h408, 32'h0, 32'h12345678, "rd1");

    sram_write   = 1'b1;
    sram_address = 32'h40C;
    sram_wdata   = 32'h55AA1234;
    step();
    sram_write = 1'b0;
    step();
    step();
    chk("mid_in_high", 32'(addr), 32'(hw_addr(32'h40C, 1'b1)));
    #2 rst = 1'b1;
    #1 chk_reset("mid");
    step();
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (sram_ready) extra++;
    end
    chk("mid_no_ready", extra, 32'd0);
    chk("mid_idle_ce", 32'(ce_n), 32'd1);

    access(1'b0, 1'b1, 32'h408, 32'h0, 32'h12345678, "rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
